// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one icache read at a time and
// queues returned words with their PCs for decode; redirects flush and restart.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BUF_DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_if,
  output logic            creq_valid,
  output logic [XLEN-1:0] creq_addr,
  input  logic            creq_fulfilled,
  input  logic [XLEN-1:0] creq_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int unsigned     PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic              req_active, req_active_n;
  logic [XLEN-1:0]   creq_addr_n;
  logic [PTR_W-1:0]  head, head_n, tail, tail_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [XLEN-1:0]   mem_data [BUF_DEPTH];
  logic [XLEN-1:0]   mem_pc   [BUF_DEPTH];
  logic              push, pop, flush, pending;

  assign creq_valid = req_active;
  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[head];
  assign inst_pc    = mem_pc[head];

  // State, PC, request and FIFO registers
  always_ff @(posedge clk) begin
    if (!rst_if) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      req_active <= 1'b0;
      creq_addr  <= RESET_VECTOR;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_active <= req_active_n;
      creq_addr  <= creq_addr_n;
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      if (push) begin
        mem_data[tail] <= creq_rdata;
        mem_pc[tail]   <= pc;
      end
    end
  end

  // Next-state, request control and FIFO bookkeeping
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_active_n = req_active;
    push         = 1'b0;
    flush        = 1'b0;
    pending      = req_active && !creq_fulfilled;
    pop          = inst_valid && inst_ready;

    unique case (state)
      IDLE: begin
        state_n      = FETCH;
        req_active_n = 1'b0;
      end
      FETCH, KILL: begin
        if (redirect_valid) begin
          pc_n  = redirect_pc & ~XLEN'(3);
          flush = 1'b1;
          // A still-unanswered request must complete before a new one is issued
          state_n = pending ? KILL : FETCH;
        end else begin
          if (req_active && creq_fulfilled) begin
            if (state == FETCH) begin
              push = 1'b1;
              pc_n = pc + XLEN'(4);
            end
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (flush) begin
      count_n = '0;
      head_n  = '0;
      tail_n  = '0;
    end else begin
      count_n = count + CNT_W'(push) - CNT_W'(pop);
      head_n  = head + PTR_W'(pop);
      tail_n  = tail + PTR_W'(push);
    end

    if (state != IDLE) begin
      req_active_n = pending || flush || (count_n < DEPTH_C);
    end

    // Address holds while a request is outstanding, otherwise tracks the PC
    creq_addr_n = pending ? creq_addr : pc_n;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a transaction-level
// model of the expected instruction stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_if;
  logic        creq_valid;
  logic [31:0] creq_addr;
  logic        creq_fulfilled;
  logic [31:0] creq_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_if(rst_if),
    .creq_valid(creq_valid), .creq_addr(creq_addr),
    .creq_fulfilled(creq_fulfilled), .creq_rdata(creq_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_stale, m_pend, m_rst;
  logic [31:0] m_pend_addr;
  int          m_since, m_gap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the expected stream across the coming clock edge
  task automatic model_update();
    if (!rst_if) begin
      m_q.delete();
      m_pc = 32'h0; m_stale = 1'b0; m_pend = 1'b0; m_rst = 1'b1;
      m_since = 0; m_gap = 0;
      return;
    end
    m_rst = 1'b0;
    m_since++;
    m_pend      = creq_valid && !creq_fulfilled;
    m_pend_addr = creq_addr;
    if (redirect_valid && m_since >= 2) begin
      m_q.delete();
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_stale = creq_valid && !creq_fulfilled;
    end else begin
      if (inst_valid && inst_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (creq_valid && creq_fulfilled) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          m_q.push_back('{pc: creq_addr, data: creq_rdata});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic model_check();
    if (m_rst) begin
      check("rst_creq_valid", 32'(creq_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      return;
    end
    check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("inst_pc", inst_pc, m_q[0].pc);
      check("inst_data", inst_data, m_q[0].data);
    end
    if (m_pend) begin
      check("hold_valid", 32'(creq_valid), 32'd1);
      check("hold_addr", creq_addr, m_pend_addr);
    end else if (creq_valid) begin
      check("req_addr", creq_addr, m_pc);
      check("req_space", 32'(m_q.size() < int'(DEPTH)), 32'd1);
    end
    if (creq_valid) check("addr_align", 32'(creq_addr[1:0]), 32'd0);
    if (!creq_valid && m_q.size() < int'(DEPTH)) m_gap++;
    else m_gap = 0;
    check("issue_gap", 32'(m_gap <= 1), 32'd1);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic quiet();
    creq_fulfilled = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; creq_rdata = 32'h0;
  endtask

  task automatic do_reset(input int n);
    rst_if = 1'b0; quiet();
    repeat (n) tick();
    rst_if = 1'b1;
  endtask

  // Step with the icache answering every request in the cycle it is presented
  task automatic serve0();
    creq_fulfilled = creq_valid;
    creq_rdata     = creq_addr ^ 32'h5A5A_0000;
    tick();
    quiet();
  endtask

  task automatic wait_req(input string tag);
    int c = 0;
    while (!creq_valid && c < 4) begin tick(); c++; end
    check(tag, 32'(creq_valid), 32'd1);
  endtask

  logic [31:0] fa[$];
  logic [31:0] pp[$];
  logic        seen;

  initial begin
    rst_if = 1'b0; inst_ready = 1'b0; quiet();
    m_q.delete(); m_pc = 32'h0; m_stale = 1'b0; m_pend = 1'b0; m_rst = 1'b1;
    m_since = 0; m_gap = 0; m_pend_addr = 32'h0;
    @(negedge clk);

    // Sequential fetch, icache answers one cycle after the request appears
    do_reset(2);
    inst_ready = 1'b1; seen = 1'b0;
    for (int c = 0; c < 30 && pp.size() < 3; c++) begin
      logic v;
      v = creq_valid;
      creq_fulfilled = creq_valid && seen;
      creq_rdata     = creq_addr ^ 32'hDEAD_0000;
      if (creq_fulfilled) fa.push_back(creq_addr);
      if (inst_valid && inst_ready) pp.push_back(inst_pc);
      seen = v && !creq_fulfilled;
      tick();
    end
    quiet();
    check("t1_npop", 32'(pp.size()), 32'd3);
    check("t1_req0", fa[0], 32'h0);
    check("t1_req1", fa[1], 32'h4);
    check("t1_req2", fa[2], 32'h8);
    check("t1_pc0", pp[0], 32'h0);
    check("t1_pc1", pp[1], 32'h4);
    check("t1_pc2", pp[2], 32'h8);

    // Back-pressure: the FIFO fills and fetching stops
    do_reset(2);
    inst_ready = 1'b0; fa.delete();
    for (int c = 0; c < 10; c++) begin
      if (creq_valid) fa.push_back(creq_addr);
      serve0();
    end
    check("t2_nreq", 32'(fa.size()), 32'd2);
    check("t2_req0", fa[0], 32'h0);
    check("t2_req1", fa[1], 32'h4);
    check("t2_stall", 32'(creq_valid), 32'd0);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    wait_req("t2_resume");
    check("t2_req2", creq_addr, 32'h8);

    // Redirect while 0x8 misses for five cycles
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); quiet();
    check("t3_flush", 32'(inst_valid), 32'd0);
    check("t3_stale_addr", creq_addr, 32'h8);
    repeat (2) begin
      tick();
      check("t3_hold", creq_addr, 32'h8);
    end
    creq_fulfilled = 1'b1; creq_rdata = 32'hBAD0_0008;
    tick(); quiet();
    inst_ready = 1'b1;
    wait_req("t3_resume");
    check("t3_new_addr", creq_addr, 32'h100);

    // Redirect coinciding with the response for 0x10
    do_reset(1);
    for (int c = 0; c < 40 && !(creq_valid && creq_addr == 32'h10); c++) serve0();
    check("t4_reach", creq_addr, 32'h10);
    creq_fulfilled = 1'b1; creq_rdata = 32'hBAD0_0010;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick(); quiet();
    check("t4_addr", creq_addr, 32'h200);
    check("t4_flush", 32'(inst_valid), 32'd0);

    // PC wrap at the top of the address space
    creq_fulfilled = creq_valid; creq_rdata = 32'h1234_5678;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); quiet();
    check("t5_addr_top", creq_addr, 32'hFFFF_FFFC);
    serve0();
    check("t5_wrap", creq_addr, 32'h0);
    check("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);

    // Reset with a full FIFO, then restart at the reset vector
    inst_ready = 1'b0;
    repeat (6) serve0();
    check("t6_full", 32'(inst_valid), 32'd1);
    rst_if = 1'b0; tick();
    check("t6_rst_valid", 32'(creq_valid), 32'd0);
    check("t6_rst_inst", 32'(inst_valid), 32'd0);
    rst_if = 1'b1; inst_ready = 1'b1;
    wait_req("t6_restart");
    check("t6_addr", creq_addr, 32'h0);

    // Randomized traffic: variable latency, redirects, back-pressure, resets
    for (int c = 0; c < 4000; c++) begin
      rst_if         = ($urandom_range(0, 499) != 0);
      inst_ready     = ($urandom_range(0, 9) < 7);
      creq_fulfilled = rst_if && creq_valid && ($urandom_range(0, 9) < 6);
      creq_rdata     = $urandom;
      redirect_valid = rst_if && (m_since >= 1) && ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      tick();
    end
    quiet(); rst_if = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
